// File: rtl/imm_ext_pipe.sv
// LEGv8 immediate extractor with a one-deep valid/ready output register
// and a saturating count of accepted illegal instructions.
module imm_ext_pipe #(
    parameter int N        = 64,
    parameter int BR_SHIFT = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    input  logic             clr_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [6:0]       NW   = 7'(N);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             w_is_d;
    logic             w_is_cb;
    logic             w_is_b;
    logic             w_is_i;
    logic             w_is_iw;
    logic             w_iw_ok;
    logic [6:0]       w_iw_top;
    logic [N-1:0]     w_d_ext;
    logic [N-1:0]     w_cb_ext;
    logic [N-1:0]     w_b_ext;
    logic [N-1:0]     w_i_ext;
    logic [N-1:0]     w_iw_ext;
    logic [N-1:0]     w_imm;
    logic [2:0]       w_fmt;
    logic             w_illegal;
    logic             w_acc;

    logic             r_valid;
    logic [N-1:0]     r_imm;
    logic [2:0]       r_fmt;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    assign w_is_d  = (instr[31:21] == 11'b111_1100_0010) ||
                     (instr[31:21] == 11'b111_1100_0000);
    assign w_is_cb = (instr[31:25] == 7'b1011_010);
    assign w_is_b  = (instr[31:26] == 6'b000101);
    assign w_is_i  = (instr[31:22] == 10'b1001000100) ||
                     (instr[31:22] == 10'b1101000100);
    assign w_is_iw = (instr[31:23] == 9'b110100101);

    // MOVZ is only legal when the shifted halfword fits inside N bits
    assign w_iw_top = {1'b0, instr[22:21], 4'b0000} + 7'd16;
    assign w_iw_ok  = (w_iw_top <= NW);

    assign w_d_ext  = {{(N-9){instr[20]}}, instr[20:12]};
    assign w_i_ext  = {{(N-12){1'b0}}, instr[21:10]};
    assign w_iw_ext = {{(N-16){1'b0}}, instr[20:5]}
                      << {instr[22:21], 4'b0000};
    assign w_cb_ext = (BR_SHIFT != 0)
                      ? ({{(N-19){instr[23]}}, instr[23:5]} << 2)
                      : {{(N-19){instr[23]}}, instr[23:5]};
    assign w_b_ext  = (BR_SHIFT != 0)
                      ? ({{(N-26){instr[25]}}, instr[25:0]} << 2)
                      : {{(N-26){instr[25]}}, instr[25:0]};

    always_comb begin
        w_imm     = '0;
        w_fmt     = 3'd0;
        w_illegal = 1'b0;
        unique case (1'b1)
            w_is_d: begin
                w_imm = w_d_ext;
                w_fmt = 3'd1;
            end
            w_is_cb: begin
                w_imm = w_cb_ext;
                w_fmt = 3'd2;
            end
            w_is_b: begin
                w_imm = w_b_ext;
                w_fmt = 3'd3;
            end
            w_is_i: begin
                w_imm = w_i_ext;
                w_fmt = 3'd4;
            end
            w_is_iw: begin
                if (w_iw_ok) begin
                    w_imm = w_iw_ext;
                    w_fmt = 3'd5;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign in_ready = !r_valid || out_ready;
    assign w_acc    = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_imm     <= '0;
            r_fmt     <= 3'd0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_acc) begin
                r_valid   <= 1'b1;
                r_imm     <= w_imm;
                r_fmt     <= w_fmt;
                r_illegal <= w_illegal;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (clr_count) begin
                r_cnt <= '0;
            end else if (w_acc && w_illegal && (r_cnt != CMAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_valid;
    assign imm       = r_imm;
    assign fmt       = r_fmt;
    assign illegal   = r_illegal;
    assign err_count = r_cnt;

endmodule
